// File: rtl/div_unit_pkg.sv
//==============================================================================
// Module  : div_unit_pkg
// Purpose : Shared definitions for the EX-stage divider.
//           - Textual defines used across the EX stage:
//             state encodings, handshake levels, bus widths and the DIV/DIVU
//             ALU opcodes.
//           - A typed state enumeration built on the encodings.
// Ports   : none (package)
// Options : none
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

`ifndef DIV_UNIT_DEFINES
`define DIV_UNIT_DEFINES

// Divider state encodings
`define DivFree            2'b00
`define DivByZero          2'b01
`define DivOn              2'b10
`define DivEnd             2'b11

// Handshake levels
`define DivResultReady     1'b1
`define DivResultNotReady  1'b0
`define DivStart           1'b1
`define DivStop            1'b0

// Register bus widths
`define RegBus             31:0
`define DoubleRegBus       63:0

// EX-stage ALU opcodes that route to the divider
`define EXE_DIV_OP         8'b00011010
`define EXE_DIVU_OP        8'b00011011

`endif

package div_unit_pkg;

   typedef enum logic [1:0] {
      DIV_FREE    = `DivFree,
      DIV_BY_ZERO = `DivByZero,
      DIV_ON      = `DivOn,
      DIV_END     = `DivEnd
   } div_state_t;

endpackage : div_unit_pkg

`default_nettype wire

// File: rtl/div_unit.sv
//==============================================================================
// Module  : div_unit
// Purpose : Multi-cycle radix-2 restoring divider for DIV / DIVU.
//           The operands are latched on the start edge. Signed operands are
//           first reduced to magnitudes. One quotient bit is produced per
//           cycle, MSB first. The signs are applied again when the result is
//           presented. A zero divisor skips the iterations and returns zero.
// Ports   : clk           in   rising-edge clock
//           rst           in   synchronous reset, active-high
//           signed_div_i  in   1 = DIV (signed), 0 = DIVU
//           opdata1_i     in   [DATA_W-1:0] dividend
//           opdata2_i     in   [DATA_W-1:0] divisor
//           start_i       in   request, held by EX until ready_o is seen
//           annul_i       in   cancel an in-flight division
//           result_o      out  [2*DATA_W-1:0] {remainder, quotient}
//           ready_o       out  result valid this cycle
//           div_zero_o    out  divisor was zero (DIV_ZERO_FLAG_EN only)
// Options : DIV_ZERO_FLAG_EN - adds the div_zero_o port
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module div_unit
   import div_unit_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 6
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  signed_div_i,
   input  logic [DATA_W-1:0]     opdata1_i,
   input  logic [DATA_W-1:0]     opdata2_i,
   input  logic                  start_i,
   input  logic                  annul_i,
   output logic [2*DATA_W-1:0]   result_o,
`ifdef DIV_ZERO_FLAG_EN
   output logic                  ready_o,
   output logic                  div_zero_o
`else
   output logic                  ready_o
`endif
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   // Conditional two's-complement negation. Used to take magnitudes on entry
   // and to restore the signs on exit.
   function automatic logic [DATA_W-1:0] cond_neg(input logic [DATA_W-1:0] v,
                                                  input logic              neg);
      return neg ? (-v) : v;
   endfunction

   div_state_t            state;
   div_state_t            state_nxt;

   logic [CNT_W-1:0]      cnt;
   logic [DATA_W-1:0]     rem;        // partial remainder
   logic [DATA_W-1:0]     dvd;        // dividend bits shift out, quotient bits shift in
   logic [DATA_W-1:0]     dsr;        // divisor magnitude
   logic                  neg_quo;    // quotient sign must be flipped on exit
   logic                  neg_rem;    // remainder follows the dividend sign
`ifdef DIV_ZERO_FLAG_EN
   logic                  zero_seen;
`endif

   logic                  start_ok;
   logic                  divisor_zero;
   logic [DATA_W:0]       shifted;
   logic [DATA_W+1:0]     trial;
   logic                  trial_ge;

   assign start_ok     = (start_i == `DivStart) && !annul_i;
   assign divisor_zero = (opdata2_i == '0);

   // One restoring step: bring the next dividend bit into the remainder. The
   // shifted remainder can need DATA_W+1 bits, and the subtraction keeps one
   // more bit as the borrow.
   assign shifted  = {rem, dvd[DATA_W-1]};
   assign trial    = {1'b0, shifted} - {2'b00, dsr};
   assign trial_ge = ~trial[DATA_W+1];

   //---------------------------------------------------------------------------
   // State register
   //---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= DIV_FREE;
      end else begin
         state <= state_nxt;
      end
   end

   //---------------------------------------------------------------------------
   // Next-state logic
   //---------------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      unique case (state)
         DIV_FREE: begin
            if (start_ok) begin
               state_nxt = divisor_zero ? DIV_BY_ZERO : DIV_ON;
            end
         end
         DIV_BY_ZERO: begin
            state_nxt = DIV_END;
         end
         DIV_ON: begin
            if (annul_i) begin
               state_nxt = DIV_FREE;
            end else if (cnt == CNT_LAST) begin
               state_nxt = DIV_END;
            end
         end
         DIV_END: begin
            // EX keeps start high until it has consumed the result.
            if (start_i == `DivStop) begin
               state_nxt = DIV_FREE;
            end
         end
         default: begin
            state_nxt = DIV_FREE;
         end
      endcase
   end

   //---------------------------------------------------------------------------
   // Datapath registers
   //---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt       <= '0;
         rem       <= '0;
         dvd       <= '0;
         dsr       <= '0;
         neg_quo   <= 1'b0;
         neg_rem   <= 1'b0;
`ifdef DIV_ZERO_FLAG_EN
         zero_seen <= 1'b0;
`endif
      end else begin
         unique case (state)
            DIV_FREE: begin
               if (start_ok) begin
                  cnt <= '0;
                  rem <= '0;
                  if (divisor_zero) begin
                     // The quotient and the remainder both read as zero.
                     dvd     <= '0;
                     dsr     <= '0;
                     neg_quo <= 1'b0;
                     neg_rem <= 1'b0;
                  end else begin
                     dvd     <= cond_neg(opdata1_i, signed_div_i & opdata1_i[DATA_W-1]);
                     dsr     <= cond_neg(opdata2_i, signed_div_i & opdata2_i[DATA_W-1]);
                     neg_quo <= signed_div_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
                     neg_rem <= signed_div_i & opdata1_i[DATA_W-1];
                  end
`ifdef DIV_ZERO_FLAG_EN
                  zero_seen <= divisor_zero;
`endif
               end
            end
            DIV_ON: begin
               cnt <= cnt + CNT_ONE;
               // When the trial subtraction fails, shifted is smaller than the
               // divisor, so its low DATA_W bits hold the whole value.
               rem <= trial_ge ? trial[DATA_W-1:0] : shifted[DATA_W-1:0];
               dvd <= {dvd[DATA_W-2:0], trial_ge};
            end
            default: begin
            end
         endcase
      end
   end

   //---------------------------------------------------------------------------
   // Outputs: valid only in END, zero otherwise
   //---------------------------------------------------------------------------
   always_comb begin
      ready_o  = `DivResultNotReady;
      result_o = '0;
      if (state == DIV_END) begin
         ready_o  = `DivResultReady;
         result_o = {cond_neg(rem, neg_rem), cond_neg(dvd, neg_quo)};
      end
   end

`ifdef DIV_ZERO_FLAG_EN
   always_comb begin
      div_zero_o = (state == DIV_END) && zero_seen;
   end
`endif

endmodule : div_unit

`default_nettype wire
